accel_tilt_filter: RTL and testbench
====================================

ACCEL_TILT_FILTER -- requirements
Module: accel_tilt_filter

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 500000, meaning clk_50 cycles between samples (100 Hz).
REQ-002 SHALL have parameter TILT_ON, default 250, meaning the |avg| threshold (LSB, 1 mg/LSB) that asserts a tilt flag.
REQ-003 SHALL have parameter TILT_OFF, default 150, meaning the |avg| threshold below which an asserted tilt flag deasserts; TILT_OFF < TILT_ON.
REQ-004 SHALL have port clk_50  input  1  the single system clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports x_acc_reg, y_acc_reg, z_acc_reg  input  12 each  signed two's-complement accelerometer results, already synchronous to clk_50.
REQ-007 SHALL have ports x_avg, y_avg, z_avg  output  12 each  signed 8-sample moving averages.
REQ-008 SHALL have port avg_valid  output  1  one-cycle pulse when the averages and tilt flags update.
REQ-009 SHALL have ports tilt_left, tilt_right, tilt_fwd, tilt_back  output  1 each  hysteretic tilt direction flags.
REQ-010 SHALL have port filter_full  output  1  high once 8 samples have been accumulated since reset.

Function
REQ-011 Tick counter SHALL count 0..SAMPLE_DIV-1 and wrap; wrap cycle issues one sample request.
REQ-012 Sequencer states: S_WAIT, S_X, S_Y, S_Z, S_DONE; S_WAIT->S_X on tick, S_X->S_Y->S_Z->S_DONE->S_WAIT unconditionally, one cycle each.
REQ-013 In S_WAIT on tick, all three inputs SHALL be captured into holding registers simultaneously (coherent sample).
REQ-014 Each axis SHALL keep an 8-entry history and a 15-bit signed running sum; in its state: sum <= sum + new - oldest, new sample overwrites oldest, write pointer (3-bit) wraps 7->0.
REQ-015 Average SHALL be sum arithmetically shifted right by 3 (floor toward negative infinity), truncated to 12 bits; no saturation is needed (range -2048..2047 preserved).
REQ-016 In S_DONE, averages, tilt flags, and filter_full SHALL be registered and avg_valid pulses one cycle; latency from tick to avg_valid is exactly 4 clk_50 cycles.
REQ-017 Sample counter SHALL saturate at 8; filter_full asserts in the S_DONE of the 8th sample; before that avg_valid still pulses but all tilt flags stay 0.
REQ-018 tilt_right SHALL set when x_avg > TILT_ON and clear when x_avg < TILT_OFF; tilt_left symmetric on x_avg < -TILT_ON / > -TILT_OFF; tilt_fwd/tilt_back same on y_avg (positive = fwd).
REQ-019 tilt_left and tilt_right SHALL never both be 1 (likewise fwd/back); the thresholds guarantee this.
REQ-020 z_avg is filtered but SHALL NOT affect any tilt flag.
REQ-021 Changes on the input ports between ticks SHALL have no effect; a tick arriving while not in S_WAIT cannot occur (SAMPLE_DIV >= 5 is required and SHALL be checked by an elaboration assertion).

Reset
REQ-022 While reset is high at a clk_50 edge: tick counter, pointers, sample counter, histories, sums = 0; state = S_WAIT; all outputs = 0.
REQ-023 Reset asserted mid-sequence (any state) SHALL abort the sample with no avg_valid pulse; the next sample follows SAMPLE_DIV cycles after release.

Structure
REQ-024 State encodings, history depth (8) and its log2 (3) SHALL live in shared package accel_pkg.
REQ-025 Per-axis history/sum/average logic SHALL be sub-module accel_avg_axis (enable, sample in, average out), instantiated three times.

Verification
REQ-026 SAMPLE_DIV=8, constant x=100,y=-100,z=1000 for 8 ticks -> filter_full on 8th avg_valid, x_avg=100, y_avg=-100, z_avg=1000, all flags 0.
REQ-027 Step x 0->400 after full -> x_avg 50,100,...,400 on successive avg_valid; tilt_right sets on the first avg_valid with x_avg>250 (x_avg=300).
REQ-028 Hysteresis: x_avg held at 200 after tilt_right set -> stays 1; drop to 100 -> clears on that avg_valid.
REQ-029 Extremes x=-2048 for 8 samples -> x_avg=-2048, tilt_left=1; x=2047 -> x_avg=2047; x=-1 single sample amid zeros -> x_avg=-1 (floor).
REQ-030 Reset pulsed in S_Y -> no avg_valid, all outputs 0, filter_full 0 until 8 new samples.
REQ-031 avg_valid spacing = SAMPLE_DIV cycles; tick-to-avg_valid = 4 cycles; input toggling between ticks ignored.

Source files
------------

// File: rtl/accel_pkg.sv
`default_nettype none
//============================================================================
// Module   : accel_pkg
// Brief    : Shared sequencer states, history geometry and helpers for the
//            accelerometer tilt filter.
// Revision : 1.0 - initial release
//============================================================================
package accel_pkg;

    localparam int c_hist_depth = 8;
    localparam int c_hist_log2  = 3;
    localparam int c_data_w     = 12;
    localparam int c_sum_w      = c_data_w + c_hist_log2;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_X    = 3'd1,
        S_Y    = 3'd2,
        S_Z    = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Hysteresis update: set wins, then clear, otherwise hold.
    function automatic logic hyst_next(input logic cur, input logic set_cond, input logic clr_cond);
        return set_cond ? 1'b1 : (clr_cond ? 1'b0 : cur);
    endfunction

endpackage
`default_nettype wire

// File: rtl/accel_avg_axis.sv
`default_nettype none
//============================================================================
// Module   : accel_avg_axis
// Brief    : One axis of the 8-sample moving average (history ring + sum).
// Revision : 1.0 - initial release
//============================================================================
module accel_avg_axis
    import accel_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [c_data_w-1:0] sample,
    output logic signed [c_data_w-1:0] avg
);

    logic signed [c_data_w-1:0]  r_hist [c_hist_depth];
    logic [c_hist_log2-1:0]      r_wr_ptr;
    logic signed [c_sum_w-1:0]   r_sum;
    logic signed [c_sum_w-1:0]   w_sum_next;
    logic signed [c_sum_w-1:0]   w_sum_out;

    // While enabled the average already reflects the incoming sample, so the
    // last axis of a sequence can be registered in the same cycle it updates.
    always_comb begin
        w_sum_next = r_sum
                   + {{c_hist_log2{sample[c_data_w-1]}}, sample}
                   - {{c_hist_log2{r_hist[r_wr_ptr][c_data_w-1]}}, r_hist[r_wr_ptr]};
        w_sum_out  = en ? w_sum_next : r_sum;
    end

    // Dropping the low bits is an arithmetic shift right by 3 (floor).
    assign avg = w_sum_out[c_sum_w-1:c_hist_log2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_sum    <= '0;
            for (int i = 0; i < c_hist_depth; i++) begin
                r_hist[i] <= '0;
            end
        end else if (en) begin
            r_sum            <= w_sum_next;
            r_hist[r_wr_ptr] <= sample;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/accel_tilt_filter.sv
`default_nettype none
//============================================================================
// Module   : accel_tilt_filter
// Brief    : Periodic 3-axis sampling, 8-sample moving average and
//            hysteretic tilt direction flags.
// Revision : 1.0 - initial release
//============================================================================
module accel_tilt_filter
    import accel_pkg::*;
#(
    parameter int SAMPLE_DIV = 500000,
    parameter int TILT_ON    = 250,
    parameter int TILT_OFF   = 150
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic signed [11:0] x_acc_reg,
    input  logic signed [11:0] y_acc_reg,
    input  logic signed [11:0] z_acc_reg,
    output logic signed [11:0] x_avg,
    output logic signed [11:0] y_avg,
    output logic signed [11:0] z_avg,
    output logic               avg_valid,
    output logic               tilt_left,
    output logic               tilt_right,
    output logic               tilt_fwd,
    output logic               tilt_back,
    output logic               filter_full
);

    if (SAMPLE_DIV < 5) begin : g_chk_sample_div
        $error("accel_tilt_filter: SAMPLE_DIV must be at least 5");
    end
    if (TILT_OFF >= TILT_ON) begin : g_chk_thresholds
        $error("accel_tilt_filter: TILT_OFF must be below TILT_ON");
    end

    localparam int                        c_cnt_w    = $clog2(SAMPLE_DIV);
    localparam logic [c_cnt_w-1:0]        c_div_last = c_cnt_w'(SAMPLE_DIV - 1);
    localparam logic [c_hist_log2:0]      c_full_cnt = (c_hist_log2 + 1)'(c_hist_depth);
    localparam logic signed [11:0]        c_on_pos   = 12'(TILT_ON);
    localparam logic signed [11:0]        c_off_pos  = 12'(TILT_OFF);
    localparam logic signed [11:0]        c_on_neg   = 12'(-TILT_ON);
    localparam logic signed [11:0]        c_off_neg  = 12'(-TILT_OFF);

    logic [c_cnt_w-1:0]      r_tick_cnt;
    logic                    w_tick;
    state_t                  r_state;
    logic signed [11:0]      r_x_hold, r_y_hold, r_z_hold;
    logic [c_hist_log2:0]    r_samp_cnt;
    logic                    w_full;
    logic signed [11:0]      w_x_avg, w_y_avg, w_z_avg;

    assign w_tick = (r_tick_cnt == c_div_last);
    assign w_full = (r_samp_cnt == c_full_cnt);

    always_ff @(posedge clk_50) begin
        if (reset || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    accel_avg_axis u_axis_x (.clk(clk_50), .rst(reset), .en(r_state == S_X), .sample(r_x_hold), .avg(w_x_avg));
    accel_avg_axis u_axis_y (.clk(clk_50), .rst(reset), .en(r_state == S_Y), .sample(r_y_hold), .avg(w_y_avg));
    accel_avg_axis u_axis_z (.clk(clk_50), .rst(reset), .en(r_state == S_Z), .sample(r_z_hold), .avg(w_z_avg));

    // Outputs load on entry to S_DONE so they are presented, with the
    // avg_valid pulse, during S_DONE: four cycles after the tick.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state     <= S_WAIT;
            r_x_hold    <= '0;
            r_y_hold    <= '0;
            r_z_hold    <= '0;
            r_samp_cnt  <= '0;
            x_avg       <= '0;
            y_avg       <= '0;
            z_avg       <= '0;
            avg_valid   <= 1'b0;
            tilt_left   <= 1'b0;
            tilt_right  <= 1'b0;
            tilt_fwd    <= 1'b0;
            tilt_back   <= 1'b0;
            filter_full <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (w_tick) begin
                        r_x_hold <= x_acc_reg;
                        r_y_hold <= y_acc_reg;
                        r_z_hold <= z_acc_reg;
                        r_state  <= S_X;
                    end
                end
                S_X: begin
                    if (!w_full) begin
                        r_samp_cnt <= r_samp_cnt + 1'b1;
                    end
                    r_state <= S_Y;
                end
                S_Y: r_state <= S_Z;
                S_Z: begin
                    x_avg       <= w_x_avg;
                    y_avg       <= w_y_avg;
                    z_avg       <= w_z_avg;
                    avg_valid   <= 1'b1;
                    filter_full <= w_full;
                    tilt_right  <= w_full & hyst_next(tilt_right, w_x_avg > c_on_pos,  w_x_avg < c_off_pos);
                    tilt_left   <= w_full & hyst_next(tilt_left,  w_x_avg < c_on_neg,  w_x_avg > c_off_neg);
                    tilt_fwd    <= w_full & hyst_next(tilt_fwd,   w_y_avg > c_on_pos,  w_y_avg < c_off_pos);
                    tilt_back   <= w_full & hyst_next(tilt_back,  w_y_avg < c_on_neg,  w_y_avg > c_off_neg);
                    r_state     <= S_DONE;
                end
                S_DONE:  r_state <= S_WAIT;
                default: r_state <= S_WAIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_tilt_filter.sv
`default_nettype none
//============================================================================
// Module   : tb_accel_tilt_filter
// Brief    : Self-checking bench: directed vector table plus randomized
//            samples against a behavioural moving-average/hysteresis model.
// Revision : 1.0 - initial release
//============================================================================
module tb_accel_tilt_filter;

    localparam int SAMPLE_DIV = 8;
    localparam int TILT_ON    = 250;
    localparam int TILT_OFF   = 150;

    logic               clk_50 = 1'b0;
    logic               reset  = 1'b1;
    logic signed [11:0] x_acc_reg = '0, y_acc_reg = '0, z_acc_reg = '0;
    logic signed [11:0] x_avg, y_avg, z_avg;
    logic               avg_valid, tilt_left, tilt_right, tilt_fwd, tilt_back, filter_full;

    accel_tilt_filter #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .TILT_ON    (TILT_ON),
        .TILT_OFF   (TILT_OFF)
    ) dut (
        .clk_50      (clk_50),
        .reset       (reset),
        .x_acc_reg   (x_acc_reg),
        .y_acc_reg   (y_acc_reg),
        .z_acc_reg   (z_acc_reg),
        .x_avg       (x_avg),
        .y_avg       (y_avg),
        .z_avg       (z_avg),
        .avg_valid   (avg_valid),
        .tilt_left   (tilt_left),
        .tilt_right  (tilt_right),
        .tilt_fwd    (tilt_fwd),
        .tilt_back   (tilt_back),
        .filter_full (filter_full)
    );

    always #5 clk_50 = ~clk_50;

    int n_cmp  = 0;
    int n_fail = 0;
    bit first_after_reset = 1'b0;

    typedef struct {
        bit       rst;
        int       rep;
        int       x, y, z;
        int       ex, ey, ez;
        bit       efull;
        bit [3:0] eflags;   // {left, right, fwd, back}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, int rep, int x, int y, int z,
                                int ex, int ey, int ez, bit efull, bit [3:0] eflags);
        vec_t v;
        v.rst = rst; v.rep = rep; v.x = x; v.y = y; v.z = z;
        v.ex = ex; v.ey = ey; v.ez = ez; v.efull = efull; v.eflags = eflags;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int ex, input int ey, input int ez,
                              input bit efull, input bit [3:0] eflags);
        check({tag, ".x_avg"}, int'(x_avg), ex);
        check({tag, ".y_avg"}, int'(y_avg), ey);
        check({tag, ".z_avg"}, int'(z_avg), ez);
        check({tag, ".filter_full"}, int'(filter_full), int'(efull));
        check({tag, ".flags"}, int'({tilt_left, tilt_right, tilt_fwd, tilt_back}), int'(eflags));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk_50);
            #1;
            n++;
        end while (!avg_valid && n < 40);
        if (!avg_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL avg_valid_timeout: got no pulse in %0d cycles, expected one", n);
        end
    endtask

    task automatic drive(input int x, input int y, input int z);
        x_acc_reg = 12'(x);
        y_acc_reg = 12'(y);
        z_acc_reg = 12'(z);
    endtask

    task automatic drive_garbage();
        drive(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 4095)) - 2048);
    endtask

    task automatic do_reset();
        @(posedge clk_50);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk_50);
        #1 reset = 1'b0;
        first_after_reset = 1'b1;
    endtask

    // Called #1 after the edge that raised avg_valid (or right after reset).
    // Garbage is driven everywhere except around the capture edge, which is
    // SAMPLE_DIV-3 edges after the previous avg_valid.
    task automatic apply_sample(input int x, input int y, input int z);
        int n;
        if (first_after_reset) begin
            drive(x, y, z);
            wait_valid(n);
            check("first_latency", n, SAMPLE_DIV + 3);
            first_after_reset = 1'b0;
        end else begin
            drive_garbage();
            @(posedge clk_50); #1;
            check("valid_pulse_width", int'(avg_valid), 0);
            drive_garbage();
            @(posedge clk_50); #1;
            drive_garbage();
            @(posedge clk_50); #1;
            drive(x, y, z);
            repeat (2) begin
                @(posedge clk_50); #1;
            end
            drive_garbage();
            wait_valid(n);
            check("valid_spacing", n + 5, SAMPLE_DIV);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int       mh_x[$], mh_y[$], mh_z[$];
    int       m_count;
    bit [3:0] m_flags;
    int       m_ax, m_ay, m_az;

    function automatic int floor_div8(input int s);
        return (s >= 0) ? s / 8 : -((-s + 7) / 8);
    endfunction

    function automatic int window_avg(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return floor_div8(s);
    endfunction

    function automatic bit hyst(input bit cur, input bit set_c, input bit clr_c);
        if (set_c) return 1'b1;
        if (clr_c) return 1'b0;
        return cur;
    endfunction

    task automatic model_reset();
        mh_x = {0, 0, 0, 0, 0, 0, 0, 0};
        mh_y = {0, 0, 0, 0, 0, 0, 0, 0};
        mh_z = {0, 0, 0, 0, 0, 0, 0, 0};
        m_count = 0;
        m_flags = 4'b0000;
    endtask

    task automatic model_step(input int x, input int y, input int z);
        void'(mh_x.pop_front()); mh_x.push_back(x);
        void'(mh_y.pop_front()); mh_y.push_back(y);
        void'(mh_z.pop_front()); mh_z.push_back(z);
        m_ax = window_avg(mh_x);
        m_ay = window_avg(mh_y);
        m_az = window_avg(mh_z);
        if (m_count < 8) m_count++;
        if (m_count < 8) begin
            m_flags = 4'b0000;
        end else begin
            m_flags[3] = hyst(m_flags[3], m_ax < -TILT_ON, m_ax > -TILT_OFF);
            m_flags[2] = hyst(m_flags[2], m_ax >  TILT_ON, m_ax <  TILT_OFF);
            m_flags[1] = hyst(m_flags[1], m_ay >  TILT_ON, m_ay <  TILT_OFF);
            m_flags[0] = hyst(m_flags[0], m_ay < -TILT_ON, m_ay > -TILT_OFF);
        end
    endtask

    function automatic int rnd_val();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 4095)) - 2048;
            1:       return ($urandom_range(0, 1) ? 1 : -1) * int'($urandom_range(100, 400));
            2:       return 0;
            default: return $urandom_range(0, 1) ? 2047 : -2048;
        endcase
    endfunction

    task automatic model_sample(input string tag, input int x, input int y, input int z);
        apply_sample(x, y, z);
        model_step(x, y, z);
        check_outs(tag, m_ax, m_ay, m_az, m_count == 8, m_flags);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rx, ry, rz, run;

        // constant 100/-100/1000: fill-up averages and filter_full on the 8th
        tbl.push_back(mk(1, 1, 100, -100, 1000,  12,  -13,  125, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 100, -100, 1000,  25,  -25,  250, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 100, -100, 1000,  37,  -38,  375, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 100, -100, 1000,  50,  -50,  500, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 100, -100, 1000,  62,  -63,  625, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 100, -100, 1000,  75,  -75,  750, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 100, -100, 1000,  87,  -88,  875, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 100, -100, 1000, 100, -100, 1000, 1, 4'b0000));
        tbl.push_back(mk(0, 8,   0, -100, 1000,   0, -100, 1000, 1, 4'b0000));
        // step 0 -> 400: right sets on first average above 250
        tbl.push_back(mk(0, 1, 400, -100, 1000,  50, -100, 1000, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 400, -100, 1000, 100, -100, 1000, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 400, -100, 1000, 150, -100, 1000, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 400, -100, 1000, 200, -100, 1000, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 400, -100, 1000, 250, -100, 1000, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 400, -100, 1000, 300, -100, 1000, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 400, -100, 1000, 350, -100, 1000, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 400, -100, 1000, 400, -100, 1000, 1, 4'b0100));
        // hold at 200: flag stays; drop to 100: clears once below 150
        tbl.push_back(mk(0, 8, 200, -100, 1000, 200, -100, 1000, 1, 4'b0100));
        tbl.push_back(mk(0, 3, 100, -100, 1000, 162, -100, 1000, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 100, -100, 1000, 150, -100, 1000, 1, 4'b0100));
        tbl.push_back(mk(0, 1, 100, -100, 1000, 137, -100, 1000, 1, 4'b0000));
        tbl.push_back(mk(0, 3, 100, -100, 1000, 100, -100, 1000, 1, 4'b0000));
        // extremes and floor rounding
        tbl.push_back(mk(1, 8, -2048,     0,     0, -2048,     0,     0, 1, 4'b1000));
        tbl.push_back(mk(0, 8,  2047,     0,     0,  2047,     0,     0, 1, 4'b0100));
        tbl.push_back(mk(0, 8,     0, -2048,  2047,     0, -2048,  2047, 1, 4'b0001));
        tbl.push_back(mk(0, 8,     0,   400, -2048,     0,   400, -2048, 1, 4'b0010));
        tbl.push_back(mk(0, 8,     0,     0,     0,     0,     0,     0, 1, 4'b0000));
        tbl.push_back(mk(0, 1,    -1,     0,     0,    -1,     0,     0, 1, 4'b0000));
        tbl.push_back(mk(0, 1,     0,     0,     0,    -1,     0,     0, 1, 4'b0000));

        repeat (3) @(posedge clk_50);
        #1 reset = 1'b0;
        do_reset();
        check_outs("reset_state", 0, 0, 0, 1'b0, 4'b0000);
        check("reset_state.avg_valid", int'(avg_valid), 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            for (int r = 0; r < tbl[i].rep; r++) apply_sample(tbl[i].x, tbl[i].y, tbl[i].z);
            check_outs($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ez,
                       tbl[i].efull, tbl[i].eflags);
        end

        // reset while the sequencer is in S_Y aborts the sample
        do_reset();
        model_reset();
        for (int i = 0; i < 9; i++) model_sample("pre_abort", 300, -300, 5);
        drive(-700, 700, 9);
        repeat (6) begin
            @(posedge clk_50); #1;
        end
        reset = 1'b1;
        @(posedge clk_50); #1;
        reset = 1'b0;
        first_after_reset = 1'b1;
        check("abort.avg_valid", int'(avg_valid), 0);
        check_outs("abort", 0, 0, 0, 1'b0, 4'b0000);
        model_reset();
        for (int i = 0; i < 8; i++) model_sample("refill", 300, -300, 5);

        // randomized runs against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 160; i += run) begin
            run = $urandom_range(1, 6);
            rx = rnd_val(); ry = rnd_val(); rz = rnd_val();
            for (int k = 0; k < run; k++) model_sample("rand", rx, ry, rz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
